// File: rtl/servo_angle_ramp.sv
// servo_angle_ramp: accepts four target angles over a valid/ready handshake
// and slews each output angle toward its target by at most STEP degrees per
// update tick, strobing nextangle once per tick for the PWM stage.
module servo_angle_ramp #(
    parameter int unsigned TICK_CYCLES = 1000000,
    parameter int unsigned STEP        = 1,
    parameter int unsigned MAX_ANGLE   = 180,
    parameter int unsigned INIT_ANGLE  = 90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [7:0] tgt1,
    input  logic [7:0] tgt2,
    input  logic [7:0] tgt3,
    input  logic [7:0] tgt4,
    input  logic       hold,
    output logic [7:0] angle1,
    output logic [7:0] angle2,
    output logic [7:0] angle3,
    output logic [7:0] angle4,
    output logic       nextangle,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   CW       = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [8:0]    STEP9    = 9'(STEP);
    localparam logic [7:0]    MAX8     = 8'(MAX_ANGLE);
    localparam logic [7:0]    INIT8    = 8'(INIT_ANGLE);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          xfer;
    logic          step_en;
    logic          all_done;
    logic          done_nx;
    logic [7:0]    tgt_in [4];
    logic [7:0]    tgt_q  [4];
    logic [7:0]    cur    [4];
    logic [7:0]    nxt    [4];

    // Move c toward t by at most STEP, never past t.
    function automatic logic [7:0] step_toward(input logic [7:0] c, input logic [7:0] t);
        logic [8:0] d;
        logic [8:0] s;
        d = '0;
        s = '0;
        if (c < t) begin
            d = {1'b0, t} - {1'b0, c};
            s = (d < STEP9) ? d : STEP9;
            return 8'({1'b0, c} + s);
        end else if (c > t) begin
            d = {1'b0, c} - {1'b0, t};
            s = (d < STEP9) ? d : STEP9;
            return 8'({1'b0, c} - s);
        end else begin
            return c;
        end
    endfunction

    assign tgt_in[0] = tgt1;
    assign tgt_in[1] = tgt2;
    assign tgt_in[2] = tgt3;
    assign tgt_in[3] = tgt4;

    assign angle1 = cur[0];
    assign angle2 = cur[1];
    assign angle3 = cur[2];
    assign angle4 = cur[3];

    assign tick      = (cnt == CNT_LAST);
    assign tgt_ready = (state == IDLE);
    assign busy      = (state == RAMP);
    assign xfer      = tgt_valid && tgt_ready;

    // Free-running tick counter, wraps at TICK_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Candidate post-step angles and the all-channels-at-target check.
    always_comb begin
        all_done = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            nxt[i] = step_toward(cur[i], tgt_q[i]);
            if (nxt[i] != tgt_q[i]) begin
                all_done = 1'b0;
            end
        end
    end

    // Next-state logic: stepping only happens on an un-held tick in RAMP.
    always_comb begin
        state_nx = state;
        step_en  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    state_nx = RAMP;
                end
            end
            RAMP: begin
                if (tick && !hold) begin
                    step_en = 1'b1;
                    if (all_done) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register plus registered tick-aligned strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nextangle <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            nextangle <= tick;
            done      <= done_nx;
        end
    end

    // Angle and target registers; targets are clamped to MAX_ANGLE on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cur[i]   <= INIT8;
                tgt_q[i] <= INIT8;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (step_en) begin
                    cur[i] <= nxt[i];
                end
                if (xfer) begin
                    tgt_q[i] <= (tgt_in[i] > MAX8) ? MAX8 : tgt_in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp: one instance with STEP=1 (dut_a) and
// one with STEP=4 (dut_b), both ticking every 10 clocks.
module tb_servo_angle_ramp;

    localparam int TICK = 10;

    logic clk;
    logic rst_n;

    logic       va, ra, holda, nexta, busya, donea;
    logic [7:0] a_t1, a_t2, a_t3, a_t4;
    logic [7:0] a_a1, a_a2, a_a3, a_a4;

    logic       vb, rb, holdb, nextb, busyb, doneb;
    logic [7:0] b_t1, b_t2, b_t3, b_t4;
    logic [7:0] b_a1, b_a2, b_a3, b_a4;

    int vectors;
    int miscompares;

    servo_angle_ramp #(.TICK_CYCLES(TICK), .STEP(1), .MAX_ANGLE(180), .INIT_ANGLE(90)) dut_a (
        .clk(clk), .rst_n(rst_n), .tgt_valid(va), .tgt_ready(ra),
        .tgt1(a_t1), .tgt2(a_t2), .tgt3(a_t3), .tgt4(a_t4), .hold(holda),
        .angle1(a_a1), .angle2(a_a2), .angle3(a_a3), .angle4(a_a4),
        .nextangle(nexta), .busy(busya), .done(donea)
    );

    servo_angle_ramp #(.TICK_CYCLES(TICK), .STEP(4), .MAX_ANGLE(180), .INIT_ANGLE(90)) dut_b (
        .clk(clk), .rst_n(rst_n), .tgt_valid(vb), .tgt_ready(rb),
        .tgt1(b_t1), .tgt2(b_t2), .tgt3(b_t3), .tgt4(b_t4), .hold(holdb),
        .angle1(b_a1), .angle2(b_a2), .angle3(b_a3), .angle4(b_a4),
        .nextangle(nextb), .busy(busyb), .done(doneb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next nextangle pulse of the selected DUT (0=a, 1=b).
    task automatic wait_tick(input int sel, input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < 3 * TICK; k++) begin
            @(negedge clk);
            if ((sel == 0 && nexta === 1'b1) || (sel == 1 && nextb === 1'b1)) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_tick_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic send_a(input logic [7:0] t1, input logic [7:0] t2,
                          input logic [7:0] t3, input logic [7:0] t4);
        a_t1 = t1; a_t2 = t2; a_t3 = t3; a_t4 = t4;
        va = 1'b1;
        @(negedge clk);
        va = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] t1);
        b_t1 = t1; b_t2 = 8'd90; b_t3 = 8'd90; b_t4 = 8'd90;
        vb = 1'b1;
        @(negedge clk);
        vb = 1'b0;
    endtask

    initial begin
        int k;
        int exp1;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        va = 1'b0; holda = 1'b0; a_t1 = '0; a_t2 = '0; a_t3 = '0; a_t4 = '0;
        vb = 1'b0; holdb = 1'b0; b_t1 = '0; b_t2 = '0; b_t3 = '0; b_t4 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_angle1", a_a1, 90);
        chk("rst_angle4", a_a4, 90);
        chk("rst_ready", ra, 1);
        chk("rst_busy", busya, 0);
        chk("rst_next", nexta, 0);
        chk("rst_done", donea, 0);

        // Tick cadence: first strobe 10 clocks after release, then every 10
        rst_n = 1'b1;
        k = 0;
        for (int i = 1; i <= 3 * TICK; i++) begin
            @(negedge clk);
            if (nexta === 1'b1) begin k = i; break; end
        end
        chk("first_tick_cycle", k, 10);
        k = 0;
        for (int i = 1; i <= 3 * TICK; i++) begin
            @(negedge clk);
            if (nexta === 1'b1) begin k = i; break; end
        end
        chk("tick_period", k, 10);
        chk("idle_no_done", donea, 0);

        // STEP=1 ramp to (93,87,90,90)
        send_a(8'd93, 8'd87, 8'd90, 8'd90);
        chk("ramp_busy", busya, 1);
        chk("ramp_not_ready", ra, 0);
        wait_tick(0, "r1");
        chk("r1_a1", a_a1, 91); chk("r1_a2", a_a2, 89);
        chk("r1_a3", a_a3, 90); chk("r1_a4", a_a4, 90);
        chk("r1_done", donea, 0);
        wait_tick(0, "r2");
        chk("r2_a1", a_a1, 92); chk("r2_a2", a_a2, 88);
        wait_tick(0, "r3");
        chk("r3_a1", a_a1, 93); chk("r3_a2", a_a2, 87);
        chk("r3_done", donea, 1);
        @(negedge clk);
        chk("r3_done_pulse", donea, 0);
        chk("r3_ready", ra, 1);
        chk("r3_idle", busya, 0);

        // Hold mid-ramp: (93,87) -> (95,85)
        send_a(8'd95, 8'd85, 8'd90, 8'd90);
        wait_tick(0, "h1");
        chk("h1_a1", a_a1, 94); chk("h1_a2", a_a2, 86);
        holda = 1'b1;
        wait_tick(0, "h2");
        chk("h2_a1", a_a1, 94); chk("h2_busy", busya, 1);
        wait_tick(0, "h3");
        chk("h3_a2", a_a2, 86); chk("h3_busy", busya, 1); chk("h3_done", donea, 0);
        holda = 1'b0;
        wait_tick(0, "h4");
        chk("h4_a1", a_a1, 95); chk("h4_a2", a_a2, 85); chk("h4_done", donea, 1);

        // Transfer coinciding with a tick edge in IDLE
        wait_tick(0, "te0");
        repeat (TICK - 1) @(negedge clk);
        send_a(8'd97, 8'd85, 8'd90, 8'd90);
        chk("te_tick_now", nexta, 1);
        chk("te_a1_unchanged", a_a1, 95);
        chk("te_busy", busya, 1);
        wait_tick(0, "te1");
        chk("te1_a1", a_a1, 96);
        wait_tick(0, "te2");
        chk("te2_a1", a_a1, 97); chk("te2_done", donea, 1);

        // Targets equal to current angles: one tick, no change, done
        send_a(8'd97, 8'd85, 8'd90, 8'd90);
        chk("eq_busy", busya, 1);
        wait_tick(0, "eq");
        chk("eq_a1", a_a1, 97); chk("eq_done", donea, 1);

        // STEP=4: 90 -> 100 with no overshoot
        send_b(8'd100);
        wait_tick(1, "s1");
        chk("s1_b1", b_a1, 94); chk("s1_b2", b_a2, 90);
        wait_tick(1, "s2");
        chk("s2_b1", b_a1, 98); chk("s2_done", doneb, 0);
        wait_tick(1, "s3");
        chk("s3_b1", b_a1, 100); chk("s3_done", doneb, 1);

        // Target 250 clamps to 180
        send_b(8'd250);
        for (int i = 1; i <= 20; i++) begin
            wait_tick(1, "clamp");
            exp1 = (100 + 4 * i > 180) ? 180 : 100 + 4 * i;
            chk("clamp_b1", b_a1, 32'(exp1));
        end
        chk("clamp_done", doneb, 1);
        wait_tick(1, "clamp_after");
        chk("clamp_stay", b_a1, 180);

        // Reset mid-ramp
        send_a(8'd120, 8'd85, 8'd90, 8'd90);
        wait_tick(0, "mr");
        chk("mr_a1", a_a1, 98);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_a1_rst", a_a1, 90);
        chk("mr_a2_rst", a_a2, 90);
        chk("mr_busy", busya, 0);
        chk("mr_ready", ra, 1);
        @(negedge clk);
        chk("mr_done", donea, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
